// File: rtl/sobel_main_file.sv
// ----------------------------------------------------------------------------
// sobel_main_file
//
// Sobel edge-detection engine. On start it fetches every 3x3 window of an
// 8-bit grayscale image from a synchronous pixel RAM. For each interior pixel
// it computes |Gx| + |Gy|, saturated to 8 bits, and writes the
// (width-2) x (length-2) result image back to RAM in raster order.
//
// Ports:
//   clk            - sole clock, rising edge
//   n_rst          - asynchronous, active-high reset
//   start          - begin a frame (sampled only while idle)
//   width, length  - image geometry in pixels (latched on start)
//   initial_addr_r - read base, byte address = initial_addr_r << 16
//   initial_addr_w - write base, byte address = initial_addr_w << 16
//   read_data      - RAM read data, valid the cycle after read_en
//   read_en        - RAM read strobe
//   read_addr      - RAM read address
//   write_en       - RAM write strobe
//   write_addr     - RAM write address
//   write_data     - result pixel
//   busy           - high whenever the engine is not idle
//   done           - one-cycle pulse at frame completion
// ----------------------------------------------------------------------------
module sobel_main_file (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [11:0] width,
    input  logic [11:0] length,
    input  logic [7:0]  initial_addr_r,
    input  logic [7:0]  initial_addr_w,
    input  logic [7:0]  read_data,
    output logic        read_en,
    output logic [23:0] read_addr,
    output logic        write_en,
    output logic [23:0] write_addr,
    output logic [7:0]  write_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE, DONE} state_t;

    state_t      state;
    logic [11:0] w_r;
    logic [11:0] l_r;
    logic [7:0]  rbase;
    logic [7:0]  wbase;
    logic [11:0] row;
    logic [11:0] col;
    logic [3:0]  k;
    logic [7:0]  p [0:8];

    logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx, gy;
    logic [11:0]        mag;

    logic        wrap_col;
    logic        frame_end;
    logic [11:0] next_col;
    logic [11:0] next_row;

    // Address of window element idx centred on (r, c); wraps modulo 2^24.
    function automatic logic [23:0] rd_addr(input logic [7:0]  base,
                                            input logic [11:0] w,
                                            input logic [11:0] r,
                                            input logic [11:0] c,
                                            input logic [3:0]  idx);
        logic [23:0] y;
        logic [23:0] x;
        y = 24'(r) - 24'd1 + 24'(idx / 4'd3);
        x = 24'(c) - 24'd1 + 24'(idx % 4'd3);
        return {base, 16'h0000} + y * 24'(w) + x;
    endfunction

    // Output image is (w-2) wide, so interior pixel (r, c) lands at raster
    // index (r-1)*(w-2) + (c-1).
    function automatic logic [23:0] wr_addr(input logic [7:0]  base,
                                            input logic [11:0] w,
                                            input logic [11:0] r,
                                            input logic [11:0] c);
        return {base, 16'h0000} + (24'(r) - 24'd1) * (24'(w) - 24'd2)
               + 24'(c) - 24'd1;
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? 11'(-v) : 11'(v);
    endfunction

    function automatic logic [7:0] sat8(input logic [11:0] v);
        return (v > 12'd255) ? 8'd255 : v[7:0];
    endfunction

    // Gradient: each weighted half-sum is at most 4*255 = 1020, so the
    // difference fits in 11 bits signed and |Gx|+|Gy| fits in 12 bits.
    always_comb begin
        gx_pos = 11'(p[2]) + (11'(p[5]) << 1) + 11'(p[8]);
        gx_neg = 11'(p[0]) + (11'(p[3]) << 1) + 11'(p[6]);
        gy_pos = 11'(p[6]) + (11'(p[7]) << 1) + 11'(p[8]);
        gy_neg = 11'(p[0]) + (11'(p[1]) << 1) + 11'(p[2]);
        gx     = $signed(gx_pos) - $signed(gx_neg);
        gy     = $signed(gy_pos) - $signed(gy_neg);
        mag    = 12'(abs11(gx)) + 12'(abs11(gy));
    end

    // Raster advance after each write.
    always_comb begin
        wrap_col  = (col + 12'd1) == (w_r - 12'd1);
        next_col  = wrap_col ? 12'd1 : col + 12'd1;
        next_row  = wrap_col ? row + 12'd1 : row;
        frame_end = wrap_col && ((row + 12'd1) == (l_r - 12'd1));
    end

    // Strobes are decoded from state so reset clears them at once.
    assign read_en  = (state == READ);
    assign write_en = (state == WRITE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state      <= IDLE;
            w_r        <= '0;
            l_r        <= '0;
            rbase      <= '0;
            wbase      <= '0;
            row        <= '0;
            col        <= '0;
            k          <= '0;
            read_addr  <= '0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        w_r   <= width;
                        l_r   <= length;
                        rbase <= initial_addr_r;
                        wbase <= initial_addr_w;
                        if (width < 12'd3 || length < 12'd3) begin
                            state <= DONE;
                        end else begin
                            row       <= 12'd1;
                            col       <= 12'd1;
                            k         <= 4'd0;
                            read_addr <= rd_addr(initial_addr_r, width,
                                                 12'd1, 12'd1, 4'd0);
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    if (k == 4'd8) begin
                        state <= WAIT;
                    end else begin
                        k         <= k + 4'd1;
                        read_addr <= rd_addr(rbase, w_r, row, col, k + 4'd1);
                    end
                end
                WAIT: begin
                    state <= CALC;
                end
                CALC: begin
                    write_data <= sat8(mag);
                    write_addr <= wr_addr(wbase, w_r, row, col);
                    state      <= WRITE;
                end
                WRITE: begin
                    col <= next_col;
                    row <= next_row;
                    if (frame_end) begin
                        state <= DONE;
                    end else begin
                        k         <= 4'd0;
                        read_addr <= rd_addr(rbase, w_r, next_row, next_col, 4'd0);
                        state     <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Window capture: RAM returns element k-1 while element k is addressed,
    // and element 8 arrives during WAIT.
    always_ff @(posedge clk) begin
        if (state == READ && k != 4'd0) begin
            p[k - 4'd1] <= read_data;
        end else if (state == WAIT) begin
            p[8] <= read_data;
        end
    end

endmodule

// File: tb/tb_sobel_main_file.sv
module tb_sobel_main_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] width = '0;
    logic [11:0] length = '0;
    logic [7:0]  initial_addr_r = '0;
    logic [7:0]  initial_addr_w = '0;
    logic [7:0]  read_data = '0;
    logic        read_en;
    logic [23:0] read_addr;
    logic        write_en;
    logic [23:0] write_addr;
    logic [7:0]  write_data;
    logic        busy;
    logic        done;

    sobel_main_file dut (
        .clk            (clk),
        .n_rst          (rst),
        .start          (start),
        .width          (width),
        .length         (length),
        .initial_addr_r (initial_addr_r),
        .initial_addr_w (initial_addr_w),
        .read_data      (read_data),
        .read_en        (read_en),
        .read_addr      (read_addr),
        .write_en       (write_en),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    bit [7:0] mem [int];

    // Synchronous RAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (read_en)
            read_data <= mem.exists(int'(read_addr)) ? mem[int'(read_addr)] : 8'h00;
    end

    typedef struct {
        int          w;
        int          l;
        logic [7:0]  rb;
        logic [7:0]  wb;
        int          pat;
        logic [71:0] cust;
        int          exp_n;
        int          exp_done;
        int          exp_data;
        bit          mid_start;
    } vec_t;

    vec_t vecs [10];
    int errors = 0;
    int checks = 0;
    int fcyc   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int pix(input vec_t v, input int x, input int y);
        case (v.pat)
            0: return (x == v.w - 1) ? 255 : 0;
            1: return 77;
            2: return 3 * x + 5 * y;
            3: return int'(v.cust[8 * (y * 3 + x) +: 8]);
            4: return (x * 37 + y * 91 + x * y * 13) & 255;
            default: return (y >= v.l / 2) ? 255 : 0;
        endcase
    endfunction

    function automatic int model(input vec_t v, input int cx, input int cy);
        int q [9];
        int gx, gy, m;
        for (int i = 0; i < 9; i++) q[i] = pix(v, cx - 1 + i % 3, cy - 1 + i / 3);
        gx = (q[2] + 2 * q[5] + q[8]) - (q[0] + 2 * q[3] + q[6]);
        gy = (q[6] + 2 * q[7] + q[8]) - (q[0] + 2 * q[1] + q[2]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic load_mem(input vec_t v);
        mem.delete();
        for (int y = 0; y < v.l; y++)
            for (int x = 0; x < v.w; x++)
                mem[(int'(v.rb) << 16) + y * v.w + x] = 8'(pix(v, x, y));
    endtask

    task automatic kick(input vec_t v);
        @(negedge clk);
        width = 12'(v.w); length = 12'(v.l);
        initial_addr_r = v.rb; initial_addr_w = v.wb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fcyc = 0;
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        int nw, nr, done_cyc, busy_bad, overlap, limit, ex, ow;
        v = vecs[idx];
        load_mem(v);
        kick(v);
        nw = 0; nr = 0; done_cyc = -1; busy_bad = 0; overlap = 0;
        limit = 12 * v.exp_n + 20;
        ow = (v.w > 2) ? v.w - 2 : 1;
        for (int t = 0; t < limit && done_cyc < 0; t++) begin
            @(negedge clk);
            fcyc++;
            if (read_en && write_en) overlap++;
            if (!busy) busy_bad++;
            if (read_en) begin
                if (nr == 0) chk($sformatf("v%0d first_read_cycle", idx), fcyc, 1);
                if (nr < 9)
                    chk($sformatf("v%0d rd_addr%0d", idx, nr), read_addr,
                        (longint'(v.rb) << 16) + (nr / 3) * v.w + nr % 3);
                nr++;
            end
            if (write_en) begin
                ex = (v.exp_data >= 0) ? v.exp_data : model(v, nw % ow + 1, nw / ow + 1);
                chk($sformatf("v%0d wr_cycle%0d", idx, nw), fcyc, 12 * (nw + 1));
                chk($sformatf("v%0d wr_addr%0d", idx, nw), write_addr,
                    (longint'(v.wb) << 16) + nw);
                chk($sformatf("v%0d wr_data%0d", idx, nw), write_data, ex);
                nw++;
            end
            if (done) done_cyc = fcyc;
            if (v.mid_start && fcyc == 20) begin
                start = 1'b1; width = 12'd20;
            end else if (v.mid_start && fcyc == 21) begin
                start = 1'b0; width = 12'(v.w);
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
        chk($sformatf("v%0d writes", idx), nw, v.exp_n);
        chk($sformatf("v%0d reads", idx), nr, 9 * v.exp_n);
        chk($sformatf("v%0d rd_wr_overlap", idx), overlap, 0);
        chk($sformatf("v%0d busy_low_in_frame", idx), busy_bad, 0);
        @(negedge clk);
        chk($sformatf("v%0d busy_after", idx), busy, 0);
        chk($sformatf("v%0d done_after", idx), done, 0);
    endtask

    initial begin
        vec_t rv;
        int bad, dcount, d1, d2, r14, r15;

        vecs[0] = '{3,   3, 8'h00, 8'h00, 0, 72'h0, 1, 13, 255, 1'b0};
        vecs[1] = '{4,   4, 8'h00, 8'h00, 1, 72'h0, 4, 49, 0, 1'b0};
        vecs[2] = '{5,   4, 8'h12, 8'h34, 2, 72'h0, 6, 73, 64, 1'b0};
        vecs[3] = '{2, 200, 8'h00, 8'h00, 1, 72'h0, 0, 1, -1, 1'b0};
        vecs[4] = '{10,  2, 8'h05, 8'h06, 1, 72'h0, 0, 1, -1, 1'b0};
        vecs[5] = '{3,   3, 8'h00, 8'h01, 3, 72'h0000007F0000000000, 1, 13, 254, 1'b0};
        vecs[6] = '{3,   3, 8'h00, 8'h01, 3, 72'h0100007F0000000000, 1, 13, 255, 1'b0};
        vecs[7] = '{3,   3, 8'h02, 8'h00, 3, 72'h00000000007F000000, 1, 13, 254, 1'b0};
        vecs[8] = '{6,   5, 8'hFF, 8'h80, 4, 72'h0, 12, 145, -1, 1'b1};
        vecs[9] = '{5,   5, 8'h07, 8'h09, 5, 72'h0, 9, 109, -1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset read_en", read_en, 0);
        chk("reset write_en", write_en, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_frame(i);

        // Reset mid-frame of a 4x4 job
        rv = '{4, 4, 8'h12, 8'h34, 0, 72'h0, 4, 49, -1, 1'b0};
        load_mem(rv);
        kick(rv);
        repeat (30) begin
            @(negedge clk);
            fcyc++;
        end
        chk("mid read_en", read_en, 1);
        chk("mid write_data", write_data, 255);
        rst = 1'b1;
        #1;
        chk("rst read_en", read_en, 0);
        chk("rst write_en", write_en, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst read_addr", read_addr, 0);
        chk("rst write_addr", write_addr, 0);
        chk("rst write_data", write_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (read_en || write_en || busy || done) bad++;
        end
        chk("post_rst activity", bad, 0);

        // start held high: next frame accepted in first IDLE cycle after DONE
        load_mem(vecs[0]);
        @(negedge clk);
        width = 12'd3; length = 12'd3;
        initial_addr_r = 8'h00; initial_addr_w = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        fcyc = 0; dcount = 0; d1 = -1; d2 = -1; r14 = -1; r15 = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            fcyc++;
            if (fcyc == 14) r14 = int'(read_en);
            if (fcyc == 15) begin
                r15 = int'(read_en);
                start = 1'b0;
            end
            if (done) begin
                dcount++;
                if (d1 < 0) d1 = fcyc; else d2 = fcyc;
            end
        end
        chk("held done_count", dcount, 2);
        chk("held done1", d1, 13);
        chk("held done2", d2, 27);
        chk("held read_en_c14", r14, 0);
        chk("held read_en_c15", r15, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
